// File: rtl/pad_bank_pkg.sv
// pad_bank_pkg: shared types and default parameters for the pad bank controller
package pad_bank_pkg;

    typedef enum logic {
        PULL_DN = 1'b0,
        PULL_UP = 1'b1
    } pull_t;

    localparam int NCH_DEF         = 8;
    localparam int PULL_CYCLES_DEF = 16;
    localparam int CONF_W_DEF      = 8;

    // Storage width of the settle counter; PULL_CYCLES must fit below 2**CNT_MAX_W
    localparam int CNT_MAX_W = 16;

    typedef struct packed {
        logic                 last;
        logic [CNT_MAX_W-1:0] cnt;
        pull_t                pull_q;
    } chan_state_t;

endpackage

// File: rtl/pad_pull_chan.sv
// pad_pull_chan: one pad's resolved level, keeper and pull settle counter
module pad_pull_chan
    import pad_bank_pkg::*;
#(
    parameter int PULL_CYCLES = PULL_CYCLES_DEF,
    parameter int CNT_W       = $clog2(PULL_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i,
    input  logic oen,
    input  logic ren,
    input  logic pull_up,
    input  logic pad_i,
    input  logic pad_ext_drv,
    output logic res
);

    localparam logic [CNT_W-1:0] SAT = CNT_W'(PULL_CYCLES);

    chan_state_t st, st_n;
    logic        pend;
    logic        done;

    // Resolve the pad level; a floating pad keeps its last level until the pull has settled
    always_comb begin
        pend      = oen & ~pad_ext_drv & ~ren & (st.last != pull_up);
        done      = st.cnt == CNT_MAX_W'(SAT);
        res       = !oen ? i : pad_ext_drv ? pad_i : (ren | !done) ? st.last : pull_up;
        st_n.last   = res;
        st_n.pull_q = pull_t'(pull_up);
        st_n.cnt    = (pend && pull_up == st.pull_q) ? (done ? st.cnt : st.cnt + CNT_MAX_W'(1)) : '0;
    end

    // Keeper level, settle counter and previous pull selection
    always_ff @(posedge clk) begin
        if (rst)
            st <= '0;
        else
            st <= st_n;
    end

endmodule

// File: rtl/pad_bank_ctrl.sv
// pad_bank_ctrl: NCH-channel pad controller with pulls, conflict tracking and differential pairs
module pad_bank_ctrl
    import pad_bank_pkg::*;
#(
    parameter int NCH         = NCH_DEF,
    parameter int PULL_CYCLES = PULL_CYCLES_DEF,
    parameter int CNT_W       = $clog2(PULL_CYCLES + 1),
    parameter int CONF_W      = CONF_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    i,
    input  logic [NCH-1:0]    oen,
    input  logic [NCH-1:0]    ren,
    input  logic [NCH-1:0]    pull_up,
    input  logic [NCH-1:0]    ie,
    input  logic [NCH/2-1:0]  lvds_en,
    input  logic [NCH-1:0]    pad_i,
    input  logic [NCH-1:0]    pad_ext_drv,
    input  logic              conflict_clr,
    output logic [NCH-1:0]    pad_o,
    output logic [NCH-1:0]    pad_oe,
    output logic [NCH-1:0]    c,
    output logic [NCH-1:0]    pad4lvds,
    output logic [NCH-1:0]    conflict,
    output logic [CONF_W-1:0] conflict_cnt
);

    logic [NCH-1:0]   res;
    logic [NCH-1:0]   conf_now;
    logic [NCH-1:0]   c_n;
    logic [NCH/2-1:0] diff, diff_n;

    assign pad_o  = i;
    assign pad_oe = ~oen;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        pad_pull_chan #(
            .PULL_CYCLES(PULL_CYCLES),
            .CNT_W      (CNT_W)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .i          (i[g]),
            .oen        (oen[g]),
            .ren        (ren[g]),
            .pull_up    (pull_up[g]),
            .pad_i      (pad_i[g]),
            .pad_ext_drv(pad_ext_drv[g]),
            .res        (res[g])
        );
    end

    // Conflict detection, differential hysteresis and next receive data
    always_comb begin
        conf_now = ~oen & pad_ext_drv & (i ^ pad_i);
        for (int k = 0; k < NCH / 2; k++) begin
            diff_n[k]    = lvds_en[k] ? ((res[2*k] != res[2*k+1]) ? res[2*k] : diff[k]) : 1'b0;
            c_n[2*k]     = lvds_en[k] ? (res[2*k] & ie[2*k]) | diff_n[k] : res[2*k] & ie[2*k];
            c_n[2*k+1]   = lvds_en[k] ? 1'b0 : res[2*k+1] & ie[2*k+1];
        end
    end

    // Registered receive data, resolved pad level and differential state
    always_ff @(posedge clk) begin
        if (rst) begin
            c        <= '0;
            pad4lvds <= '0;
            diff     <= '0;
        end else begin
            c        <= c_n;
            pad4lvds <= res;
            diff     <= diff_n;
        end
    end

    // Sticky conflict flags and saturating conflict-cycle count; a same-cycle conflict beats clear
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict     <= '0;
            conflict_cnt <= '0;
        end else if (conflict_clr) begin
            conflict     <= conf_now;
            conflict_cnt <= CONF_W'(|conf_now);
        end else begin
            conflict <= conflict | conf_now;
            if (|conf_now && !(&conflict_cnt))
                conflict_cnt <= conflict_cnt + CONF_W'(1);
        end
    end

endmodule

// File: tb/tb_pad_bank_ctrl.sv
// tb_pad_bank_ctrl: table vectors, directed corner sequences and randomized model comparison
module tb_pad_bank_ctrl;

    localparam int NCH = 8;
    localparam int PC  = 16;
    localparam int CW  = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] i, oen, ren, pull_up, ie, pad_i, pad_ext_drv;
    logic [3:0]     lvds_en;
    logic           conflict_clr;
    logic [NCH-1:0] pad_o, pad_oe, c, pad4lvds, conflict;
    logic [CW-1:0]  conflict_cnt;

    int n_pass = 0;
    int n_chk  = 0;

    bit             m_last[NCH];
    int             m_cnt[NCH];
    bit             m_pq[NCH];
    bit             m_diff[NCH/2];
    logic [NCH-1:0] m_c, m_p4, m_conf;
    int             m_cc;

    typedef struct {
        logic [7:0] oen, i, ext, pad_i, ie;
        logic [3:0] lvds;
        logic [7:0] exp_c, exp_p4;
    } vec_t;

    vec_t tbl[5];

    pad_bank_ctrl #(.NCH(NCH), .PULL_CYCLES(PC), .CONF_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .i           (i),
        .oen         (oen),
        .ren         (ren),
        .pull_up     (pull_up),
        .ie          (ie),
        .lvds_en     (lvds_en),
        .pad_i       (pad_i),
        .pad_ext_drv (pad_ext_drv),
        .conflict_clr(conflict_clr),
        .pad_o       (pad_o),
        .pad_oe      (pad_oe),
        .c           (c),
        .pad4lvds    (pad4lvds),
        .conflict    (conflict),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic bit res_of(int ch);
        if (!oen[ch]) return i[ch];
        if (pad_ext_drv[ch]) return pad_i[ch];
        if (ren[ch]) return m_last[ch];
        if (m_last[ch] == pull_up[ch]) return pull_up[ch];
        return (m_cnt[ch] >= PC) ? pull_up[ch] : m_last[ch];
    endfunction

    task automatic model_update();
        logic [NCH-1:0] r, cf;
        bit floating_pull;
        for (int ch = 0; ch < NCH; ch++) r[ch] = res_of(ch);
        if (rst) begin
            for (int ch = 0; ch < NCH; ch++) begin
                m_last[ch] = 0; m_cnt[ch] = 0; m_pq[ch] = 0;
            end
            for (int k = 0; k < NCH / 2; k++) m_diff[k] = 0;
            m_c = '0; m_p4 = '0; m_conf = '0; m_cc = 0;
            return;
        end
        cf = ~oen & pad_ext_drv & (i ^ pad_i);
        if (conflict_clr) begin
            m_conf = cf;
            m_cc   = (cf != 0) ? 1 : 0;
        end else begin
            m_conf = m_conf | cf;
            if (cf != 0 && m_cc < 255) m_cc++;
        end
        for (int ch = 0; ch < NCH; ch++) begin
            floating_pull = oen[ch] && !pad_ext_drv[ch] && !ren[ch] && (m_last[ch] != pull_up[ch]);
            m_cnt[ch]  = (floating_pull && pull_up[ch] == m_pq[ch]) ? ((m_cnt[ch] + 1 > PC) ? PC : m_cnt[ch] + 1) : 0;
            m_pq[ch]   = pull_up[ch];
            m_last[ch] = r[ch];
        end
        for (int k = 0; k < NCH / 2; k++) begin
            if (lvds_en[k]) begin
                if (r[2*k] != r[2*k+1]) m_diff[k] = r[2*k];
                m_c[2*k]   = (r[2*k] & ie[2*k]) | m_diff[k];
                m_c[2*k+1] = 1'b0;
            end else begin
                m_diff[k]  = 0;
                m_c[2*k]   = r[2*k] & ie[2*k];
                m_c[2*k+1] = r[2*k+1] & ie[2*k+1];
            end
        end
        m_p4 = r;
    endtask

    task automatic tick();
        logic [NCH-1:0] noe;
        model_update();
        @(posedge clk);
        @(negedge clk);
        noe = ~oen;
        chk("c", c, m_c);
        chk("pad4lvds", pad4lvds, m_p4);
        chk("conflict", conflict, m_conf);
        chk("conflict_cnt", conflict_cnt, m_cc);
        chk("pad_o", pad_o, i);
        chk("pad_oe", pad_oe, noe);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic idle_inputs();
        i = '0; oen = '1; ren = '1; pull_up = '0; ie = '1; lvds_en = '0;
        pad_i = '0; pad_ext_drv = '0; conflict_clr = 1'b0;
    endtask

    initial begin
        tbl[0] = '{oen: 8'h00, i: 8'hA5, ext: 8'h00, pad_i: 8'h00, ie: 8'hFF, lvds: 4'h0, exp_c: 8'hA5, exp_p4: 8'hA5};
        tbl[1] = '{oen: 8'hFF, i: 8'h00, ext: 8'hFF, pad_i: 8'h3C, ie: 8'h0F, lvds: 4'h0, exp_c: 8'h0C, exp_p4: 8'h3C};
        tbl[2] = '{oen: 8'hF0, i: 8'h05, ext: 8'hF0, pad_i: 8'h90, ie: 8'hFF, lvds: 4'h0, exp_c: 8'h95, exp_p4: 8'h95};
        tbl[3] = '{oen: 8'h00, i: 8'h69, ext: 8'h00, pad_i: 8'h00, ie: 8'hFF, lvds: 4'h5, exp_c: 8'h49, exp_p4: 8'h69};
        tbl[4] = '{oen: 8'h00, i: 8'h69, ext: 8'h00, pad_i: 8'h00, ie: 8'h00, lvds: 4'h5, exp_c: 8'h01, exp_p4: 8'h69};

        idle_inputs();
        do_reset();
        chk("rst_c", c, 0);
        chk("rst_pad4lvds", pad4lvds, 0);
        chk("rst_conflict_cnt", conflict_cnt, 0);

        repeat (20) tick();
        chk("keeper_low", c, 0);
        oen = '0; i = 8'hFF;
        tick();
        oen = '1;
        repeat (20) tick();
        chk("keeper_high", c, 8'hFF);

        for (int j = 0; j < 5; j++) begin
            idle_inputs();
            oen = tbl[j].oen; i = tbl[j].i; pad_ext_drv = tbl[j].ext;
            pad_i = tbl[j].pad_i; ie = tbl[j].ie; lvds_en = tbl[j].lvds;
            tick();
            chk("tbl_c", c, tbl[j].exp_c);
            chk("tbl_pad4lvds", pad4lvds, tbl[j].exp_p4);
        end

        idle_inputs();
        do_reset();
        pull_up = 8'h01; oen[0] = 1'b0; i[0] = 1'b0; ren[0] = 1'b0;
        tick(); tick();
        oen[0] = 1'b1;
        for (int j = 0; j < PC; j++) begin
            tick();
            chk("settle_wait", c[0], 0);
        end
        tick();
        chk("settle_done", c[0], 1);
        oen[0] = 1'b0;
        tick();
        oen[0] = 1'b1;
        repeat (8) tick();
        oen[0] = 1'b0;
        tick();
        chk("redrive", c[0], 0);
        oen[0] = 1'b1;
        for (int j = 0; j < PC; j++) begin
            tick();
            chk("restart_wait", c[0], 0);
        end
        tick();
        chk("restart_done", c[0], 1);

        idle_inputs();
        do_reset();
        oen[3] = 1'b0; i[3] = 1'b1; pad_ext_drv[3] = 1'b1; pad_i[3] = 1'b0;
        repeat (3) tick();
        chk("conf_flag", conflict[3], 1);
        chk("conf_cnt3", conflict_cnt, 3);
        conflict_clr = 1'b1;
        tick();
        chk("clr_wins_cnt", conflict_cnt, 1);
        chk("clr_wins_flag", conflict[3], 1);
        pad_ext_drv[3] = 1'b0;
        tick();
        chk("clr_cnt", conflict_cnt, 0);
        chk("clr_flag", conflict, 0);
        conflict_clr = 1'b0;
        pad_ext_drv[3] = 1'b1;
        repeat (300) tick();
        chk("conf_sat", conflict_cnt, 255);

        idle_inputs();
        do_reset();
        lvds_en = 4'b0010; oen = 8'hF3; i[2] = 1'b1; i[3] = 1'b0;
        tick();
        chk("lvds_10_p", c[2], 1);
        chk("lvds_10_n", c[3], 0);
        i[3] = 1'b1;
        tick();
        chk("lvds_11_p", c[2], 1);
        chk("lvds_11_n", c[3], 0);
        i[2] = 1'b0;
        tick();
        chk("lvds_01_p", c[2], 0);
        chk("lvds_01_n", c[3], 0);

        idle_inputs();
        do_reset();
        ie = 8'hDF; pad_ext_drv[5] = 1'b1; pad_i[5] = 1'b1;
        tick();
        chk("ie_gate_c5", c[5], 0);
        chk("ie_gate_p4", pad4lvds[5], 1);

        idle_inputs();
        for (int seg = 0; seg < 60; seg++) begin
            int mode;
            mode = $urandom_range(0, 1);
            for (int j = 0; j < 50; j++) begin
                rst          = ($urandom_range(0, 199) == 0);
                conflict_clr = ($urandom_range(0, 15) == 0);
                if (mode == 0 || j == 0) begin
                    oen         = 8'($urandom | $urandom);
                    pad_ext_drv = 8'($urandom & $urandom);
                    ren         = 8'($urandom & $urandom);
                end
                if ($urandom_range(0, 19) == 0) pull_up = 8'($urandom);
                i       = 8'($urandom);
                pad_i   = 8'($urandom);
                ie      = 8'($urandom);
                lvds_en = 4'($urandom);
                tick();
            end
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
